// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter: request handshake with operands in,
// response handshake with result/flags/error out. Buses are flattened per requester.
interface alu_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DW      = 16
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [5*NUM_REQ-1:0]  req_opcode;
    logic [DW*NUM_REQ-1:0] req_in1;
    logic [DW*NUM_REQ-1:0] req_in2;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic [DW-1:0]         rsp_out;
    logic [2:0]            rsp_flags;
    logic                  rsp_err;

    modport master (
        output req_valid, req_opcode, req_in1, req_in2, rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_flags, rsp_err
    );

    modport slave (
        input  req_valid, req_opcode, req_in1, req_in2, rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_flags, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between NUM_REQ
// requesters; owns the architectural flag register.
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus,
    output logic [DW-1:0] alu_in1,
    output logic [DW-1:0] alu_in2,
    output logic [4:0]    alu_opcode,
    input  logic [DW-1:0] alu_out,
    input  logic [2:0]    alu_flags,
    input  logic          alu_set_flags,
    output logic [2:0]    flag_q
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_reg, state_next;
    logic [GW-1:0]   ptr_reg, ptr_next;
    logic [GW-1:0]   grant_reg, grant_next;
    logic [4:0]      opcode_reg;
    logic [DW-1:0]   in1_reg, in2_reg;
    logic [DW-1:0]   rsp_out_reg;
    logic [2:0]      rsp_flags_reg;
    logic            rsp_err_reg;
    logic [2:0]      flag_reg;

    logic [4:0]      op_arr  [NUM_REQ];
    logic [DW-1:0]   in1_arr [NUM_REQ];
    logic [DW-1:0]   in2_arr [NUM_REQ];
    logic [GW:0]     rot_sum [NUM_REQ];
    logic [GW-1:0]   rot_idx [NUM_REQ];

    logic            pick_valid;
    logic [GW-1:0]   pick_idx;
    logic            op_legal;
    logic [NUM_REQ-1:0] req_ready_c, rsp_valid_c;

    // rot_idx[k] is the requester k places after the pointer, wrapped modulo NUM_REQ
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign op_arr[gi]  = bus.req_opcode[gi*5 +: 5];
            assign in1_arr[gi] = bus.req_in1[gi*DW +: DW];
            assign in2_arr[gi] = bus.req_in2[gi*DW +: DW];
            assign rot_sum[gi] = {1'b0, ptr_reg} + (GW+1)'(gi);
            assign rot_idx[gi] = (rot_sum[gi] >= (GW+1)'(NUM_REQ))
                               ? GW'(rot_sum[gi] - (GW+1)'(NUM_REQ))
                               : rot_sum[gi][GW-1:0];
        end
    endgenerate

    // Scan farthest-first so the last hit is the one closest to the pointer
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[rot_idx[k]]) begin
                pick_valid = 1'b1;
                pick_idx   = rot_idx[k];
            end
        end
    end

    always_comb begin
        case (opcode_reg)
            5'b01010, 5'b01011, 5'b00110, 5'b00111,
            5'b10000, 5'b10001, 5'b10010, 5'b10011,
            5'b10100, 5'b10101, 5'b10110, 5'b10111,
            5'b11000, 5'b11001: op_legal = 1'b1;
            default:            op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        grant_next  = grant_reg;
        req_ready_c = '0;
        rsp_valid_c = '0;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    req_ready_c[pick_idx] = 1'b1;
                    grant_next            = pick_idx;
                    state_next            = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                rsp_valid_c[grant_reg] = 1'b1;
                if (bus.rsp_ready[grant_reg]) begin
                    ptr_next   = (grant_reg == GW'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            grant_reg     <= '0;
            opcode_reg    <= '0;
            in1_reg       <= '0;
            in2_reg       <= '0;
            rsp_out_reg   <= '0;
            rsp_flags_reg <= '0;
            rsp_err_reg   <= 1'b0;
            flag_reg      <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            grant_reg <= grant_next;
            // Operands are sampled only in the grant cycle; they hold otherwise
            if (state_reg == IDLE && pick_valid) begin
                opcode_reg <= op_arr[pick_idx];
                in1_reg    <= in1_arr[pick_idx];
                in2_reg    <= in2_arr[pick_idx];
            end
            if (state_reg == EXEC) begin
                if (op_legal) begin
                    rsp_out_reg   <= alu_out;
                    rsp_flags_reg <= alu_flags;
                    rsp_err_reg   <= 1'b0;
                    if (alu_set_flags) begin
                        flag_reg <= alu_flags;
                    end
                end else begin
                    rsp_out_reg   <= '0;
                    rsp_flags_reg <= '0;
                    rsp_err_reg   <= 1'b1;
                end
            end
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_out   = rsp_out_reg;
    assign bus.rsp_flags = rsp_flags_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign alu_opcode    = opcode_reg;
    assign alu_in1       = in1_reg;
    assign alu_in2       = in2_reg;
    assign flag_q        = flag_reg;
endmodule
